// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered scanning channel multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Round-robin channel pointer with per-channel dwell counter and a pending-wrap flag
// that marks the first channel-0 output following channel N-1.
module scan_counter
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int DWELL = 4,
    localparam int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            clear,
    output logic [SELW-1:0] ch,
    output logic            wrap_next
);

    localparam int DCW = clog2(DWELL + 1);
    localparam logic [SELW-1:0] CH_LAST = SELW'(N - 1);
    localparam logic [DCW-1:0]  DC_LAST = DCW'(DWELL - 1);

    logic [SELW-1:0] ch_q, ch_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic            wrap_pend_q, wrap_pend_d;

    always_comb begin
        ch_d        = ch_q;
        dcnt_d      = dcnt_q;
        wrap_pend_d = wrap_pend_q;
        if (clear) begin
            ch_d        = '0;
            dcnt_d      = '0;
            wrap_pend_d = 1'b0;
        end else if (run) begin
            // The pending flag is consumed by the output produced this cycle.
            wrap_pend_d = 1'b0;
            if (dcnt_q == DC_LAST) begin
                dcnt_d = '0;
                if (ch_q == CH_LAST) begin
                    ch_d        = '0;
                    wrap_pend_d = 1'b1;
                end else begin
                    ch_d = ch_q + SELW'(1);
                end
            end else begin
                dcnt_d = dcnt_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q        <= '0;
            dcnt_q      <= '0;
            wrap_pend_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            dcnt_q      <= dcnt_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    assign ch        = ch_q;
    assign wrap_next = wrap_pend_q;

endmodule

// File: rtl/mux_scan_seq.sv
// Registered N:1 channel mux with manual-select and round-robin auto-scan modes.
module mux_scan_seq
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int WIDTH = 1,
    parameter int DWELL = 4,
    localparam int SELW = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] d,
    output logic [WIDTH-1:0]   out,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    output logic               wrap
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] chan [N];
    logic [SELW-1:0]  scan_ch;
    logic             scan_wrap_next;
    logic             scan_run;
    logic             scan_clear;
    logic             sel_ok;

    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan[gi] = d[gi*WIDTH +: WIDTH];
    end

    // Out-of-range selects only exist when N does not fill the index space.
    if ((1 << SELW) == N) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (sel <= SELW'(N - 1));
    end

    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = mode ? ST_SCAN : ST_MAN;
        end
    end

    // Scan progress is cleared once on entry to manual mode so the next scan starts at channel 0.
    assign scan_run   = (state_d == ST_SCAN);
    assign scan_clear = (state_d == ST_MAN) && (state_q != ST_MAN);

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk       (clk),
        .rst       (rst),
        .run       (scan_run),
        .clear     (scan_clear),
        .ch        (scan_ch),
        .wrap_next (scan_wrap_next)
    );

    always_comb begin
        out_d    = out_q;
        out_ch_d = out_ch_q;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        case (state_d)
            ST_MAN: begin
                out_ch_d = sel;
                if (sel_ok) begin
                    out_d   = chan[sel];
                    valid_d = 1'b1;
                end else begin
                    out_d = '0;
                end
            end
            ST_SCAN: begin
                out_d    = chan[scan_ch];
                out_ch_d = scan_ch;
                valid_d  = 1'b1;
                wrap_d   = scan_wrap_next;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Randomised and directed checks of mux_scan_seq: DUT a (N=8, W=1, DWELL=4), DUT b (N=5, W=2, DWELL=1).
module tb_mux_scan_seq;

    logic clk;
    logic rst;

    logic       a_en, a_mode;
    logic [2:0] a_sel;
    logic [7:0] a_d;
    logic       a_out;
    logic [2:0] a_out_ch;
    logic       a_valid, a_wrap;

    logic       b_en, b_mode;
    logic [2:0] b_sel;
    logic [9:0] b_d;
    logic [1:0] b_out;
    logic [2:0] b_out_ch;
    logic       b_valid, b_wrap;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pos counts scan outputs produced since the scan was (re)started.
    int         pos     [2];
    logic [1:0] e_out   [2];
    logic [2:0] e_ch    [2];
    logic       e_valid [2];
    logic       e_wrap  [2];

    mux_scan_seq #(.N(8), .WIDTH(1), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .sel(a_sel), .d(a_d),
        .out(a_out), .out_ch(a_out_ch), .out_valid(a_valid), .wrap(a_wrap)
    );

    mux_scan_seq #(.N(5), .WIDTH(2), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sel(b_sel), .d(b_d),
        .out(b_out), .out_ch(b_out_ch), .out_valid(b_valid), .wrap(b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int id);
        return (id == 0) ? 8 : 5;
    endfunction

    function automatic int dw_of(input int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic logic [1:0] chan_val(input int id, input logic [15:0] d, input int k);
        logic [15:0] t;
        t = d >> (k * ((id == 0) ? 1 : 2));
        return (id == 0) ? {1'b0, t[0]} : t[1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; e_out[i] = 0; e_ch[i] = 0; e_valid[i] = 0; e_wrap[i] = 0;
        end
    endtask

    task automatic model_step(input int id, input logic en, input logic mode,
                              input logic [2:0] sel, input logic [15:0] d);
        int ch;
        if (!en) begin
            e_valid[id] = 1'b0;
            e_wrap[id]  = 1'b0;
        end else if (!mode) begin
            pos[id]    = 0;
            e_ch[id]   = sel;
            e_wrap[id] = 1'b0;
            if (int'(sel) < n_of(id)) begin
                e_out[id] = chan_val(id, d, int'(sel));
                e_valid[id] = 1'b1;
            end else begin
                e_out[id] = 2'd0;
                e_valid[id] = 1'b0;
            end
        end else begin
            ch = (pos[id] / dw_of(id)) % n_of(id);
            e_ch[id]    = 3'(ch);
            e_out[id]   = chan_val(id, d, ch);
            e_valid[id] = 1'b1;
            e_wrap[id]  = (pos[id] > 0) && (pos[id] % (n_of(id) * dw_of(id)) == 0);
            pos[id]     = pos[id] + 1;
        end
    endtask

    task automatic tick();
        model_step(0, a_en, a_mode, a_sel, {8'b0, a_d});
        model_step(1, b_en, b_mode, b_sel, {6'b0, b_d});
        @(posedge clk);
        #1;
        $display("t=%0t a: en=%0b m=%0b sel=%0d -> out=%0d ch=%0d v=%0b w=%0b | b: en=%0b m=%0b sel=%0d -> out=%0d ch=%0d v=%0b w=%0b",
                 $time, a_en, a_mode, a_sel, a_out, a_out_ch, a_valid, a_wrap,
                 b_en, b_mode, b_sel, b_out, b_out_ch, b_valid, b_wrap);
    endtask

    task automatic test_reset();
        logic [5:0] got;
        bit reached;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({a_out, a_out_ch, a_valid, a_wrap, b_out, b_out_ch, b_valid, b_wrap} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state got a=%b b=%b required all zero",
                     {a_out, a_out_ch, a_valid, a_wrap}, {b_out, b_out_ch, b_valid, b_wrap});
        end
        @(negedge clk);
        rst = 1'b0;
        a_en = 1'b1; a_mode = 1'b1; a_d = 8'hFF;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            n_vec++;
            if ({a_out, a_out_ch, a_valid, a_wrap} !== {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]}) begin
                n_err++;
                $display("FAIL reset_prescan got %b required %b",
                         {a_out, a_out_ch, a_valid, a_wrap}, {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]});
            end
            if (e_ch[0] == 3'd5) reached = 1'b1;
        end
        n_vec++;
        if (!reached) begin
            n_err++;
            $display("FAIL reset_prescan_timeout got no ch5 required ch5 within 40 cycles");
        end
        #3;
        rst = 1'b1;
        #1;
        got = {a_out, a_out_ch, a_valid, a_wrap};
        n_vec++;
        if (got !== 6'd0) begin
            n_err++;
            $display("FAIL reset_async got %b required 000000", got);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_vec++;
        if (a_out_ch !== 3'd0 || a_valid !== 1'b1 || a_out !== e_out[0][0]) begin
            n_err++;
            $display("FAIL reset_restart got ch=%0d v=%0b out=%0d required ch=0 v=1 out=%0d",
                     a_out_ch, a_valid, a_out, e_out[0][0]);
        end
    endtask

    task automatic test_manual();
        a_en = 1'b1; a_mode = 1'b0; a_d = 8'b1010_0110; a_sel = 3'd5;
        tick();
        n_vec++;
        if ({a_out, a_out_ch, a_valid, a_wrap} !== 6'b1_101_1_0 ||
            {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]} !== 6'b1_101_1_0) begin
            n_err++;
            $display("FAIL manual_sel5 got %b required 110110", {a_out, a_out_ch, a_valid, a_wrap});
        end
        a_sel = 3'd0;
        tick();
        n_vec++;
        if ({a_out, a_out_ch, a_valid, a_wrap} !== 6'b0_000_1_0) begin
            n_err++;
            $display("FAIL manual_sel0 got %b required 000010", {a_out, a_out_ch, a_valid, a_wrap});
        end
    endtask

    task automatic test_scan();
        int wraps;
        int wrap_t;
        a_en = 1'b1; a_mode = 1'b0; a_sel = 3'd2;
        tick();
        a_mode = 1'b1;
        wraps = 0; wrap_t = 0;
        for (int t = 1; t <= 33; t++) begin
            a_d = 8'($urandom);
            tick();
            n_vec++;
            if ({a_out, a_out_ch, a_valid, a_wrap} !== {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]} ||
                a_out_ch !== 3'(((t - 1) / 4) % 8)) begin
                n_err++;
                $display("FAIL scan_seq t=%0d got %b required %b", t,
                         {a_out, a_out_ch, a_valid, a_wrap}, {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]});
            end
            if (a_wrap === 1'b1) begin
                wraps++;
                wrap_t = t;
            end
        end
        n_vec++;
        if (wraps != 1 || wrap_t != 33) begin
            n_err++;
            $display("FAIL scan_wrap got %0d pulses at cycle %0d required 1 pulse at cycle 33", wraps, wrap_t);
        end
    endtask

    task automatic test_pause();
        logic [2:0] exp_ch [3];
        exp_ch[0] = 3'd2; exp_ch[1] = 3'd2; exp_ch[2] = 3'd3;
        a_en = 1'b1; a_mode = 1'b0;
        tick();
        a_mode = 1'b1;
        repeat (10) begin
            a_d = 8'($urandom);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            a_en = 1'b0;
            a_d = 8'($urandom);
            tick();
            n_vec++;
            if (a_valid !== 1'b0 || a_wrap !== 1'b0 || a_out_ch !== 3'd2 ||
                {a_out, a_out_ch} !== {e_out[0][0], e_ch[0]}) begin
                n_err++;
                $display("FAIL pause_hold got out=%0d ch=%0d v=%0b required out=%0d ch=2 v=0",
                         a_out, a_out_ch, a_valid, e_out[0][0]);
            end
        end
        a_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_d = 8'($urandom);
            tick();
            n_vec++;
            if (a_out_ch !== exp_ch[i] || a_valid !== 1'b1 || a_out !== e_out[0][0]) begin
                n_err++;
                $display("FAIL pause_resume got ch=%0d v=%0b out=%0d required ch=%0d v=1 out=%0d",
                         a_out_ch, a_valid, a_out, exp_ch[i], e_out[0][0]);
            end
        end
    endtask

    task automatic test_mode_switch();
        bit reached;
        reached = 1'b0;
        a_en = 1'b1; a_mode = 1'b1;
        for (int i = 0; i < 40 && !reached; i++) begin
            a_d = 8'($urandom);
            tick();
            if (e_ch[0] == 3'd6) reached = 1'b1;
        end
        n_vec++;
        if (!reached || a_out_ch !== 3'd6) begin
            n_err++;
            $display("FAIL switch_reach6 got ch=%0d required ch=6 within 40 cycles", a_out_ch);
        end
        a_mode = 1'b0; a_sel = 3'd1;
        tick();
        n_vec++;
        if (a_out_ch !== 3'd1 || a_valid !== 1'b1 || a_out !== a_d[1]) begin
            n_err++;
            $display("FAIL switch_to_man got ch=%0d v=%0b required ch=1 v=1", a_out_ch, a_valid);
        end
        a_mode = 1'b1;
        for (int t = 0; t < 5; t++) begin
            a_d = 8'($urandom);
            tick();
            n_vec++;
            if (a_out_ch !== ((t < 4) ? 3'd0 : 3'd1) ||
                {a_out, a_out_ch, a_valid, a_wrap} !== {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]}) begin
                n_err++;
                $display("FAIL switch_to_scan t=%0d got %b required %b", t,
                         {a_out, a_out_ch, a_valid, a_wrap}, {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]});
            end
        end
    endtask

    task automatic test_np2();
        a_en = 1'b0;
        b_en = 1'b1; b_mode = 1'b0; b_sel = 3'd6; b_d = 10'($urandom);
        tick();
        n_vec++;
        if (b_out !== 2'd0 || b_valid !== 1'b0 || b_out_ch !== 3'd6) begin
            n_err++;
            $display("FAIL np2_badsel got out=%0d ch=%0d v=%0b required out=0 ch=6 v=0", b_out, b_out_ch, b_valid);
        end
        b_mode = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            b_d = 10'($urandom);
            tick();
            n_vec++;
            if (b_out_ch !== 3'((t - 1) % 5) || b_wrap !== (t == 6 || t == 11) ||
                {b_out, b_out_ch, b_valid, b_wrap} !== {e_out[1], e_ch[1], e_valid[1], e_wrap[1]}) begin
                n_err++;
                $display("FAIL np2_scan t=%0d got %b required %b", t,
                         {b_out, b_out_ch, b_valid, b_wrap}, {e_out[1], e_ch[1], e_valid[1], e_wrap[1]});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_en = ($urandom_range(0, 7) != 0); a_mode = ($urandom_range(0, 9) < 7);
            a_sel = 3'($urandom); a_d = 8'($urandom);
            b_en = ($urandom_range(0, 7) != 0); b_mode = ($urandom_range(0, 9) < 7);
            b_sel = 3'($urandom); b_d = 10'($urandom);
            tick();
            n_vec++;
            if ({a_out, a_out_ch, a_valid, a_wrap} !== {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]}) begin
                n_err++;
                $display("FAIL random_a i=%0d got %b required %b", i,
                         {a_out, a_out_ch, a_valid, a_wrap}, {e_out[0][0], e_ch[0], e_valid[0], e_wrap[0]});
            end
            n_vec++;
            if ({b_out, b_out_ch, b_valid, b_wrap} !== {e_out[1], e_ch[1], e_valid[1], e_wrap[1]}) begin
                n_err++;
                $display("FAIL random_b i=%0d got %b required %b", i,
                         {b_out, b_out_ch, b_valid, b_wrap}, {e_out[1], e_ch[1], e_valid[1], e_wrap[1]});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_mode = 1'b0; a_sel = 3'd0; a_d = 8'd0;
        b_en = 1'b0; b_mode = 1'b0; b_sel = 3'd0; b_d = 10'd0;
        model_reset();
        test_reset();
        test_manual();
        test_scan();
        test_pause();
        test_mode_switch();
        test_np2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Parametrised, registered N:1 channel multiplexer. It is the sequential successor of the team's combinational 8:1 mux.
- Adds a manual-select mode and an auto-scan mode. Auto-scan steps round-robin through all channels, holding each for a programmable dwell time.
- Drives a registered output with a valid flag, the source channel index, and a wrap pulse.
- Sits between a bank of sampled input lines and a single downstream consumer, for example a serial monitor or probe port.

Parameters:
- N, 8, number of input channels (≥2).
- WIDTH, 1, bits per channel.
- DWELL, 4, cycles each channel is held in scan mode (≥1).
- SELW (localparam), clog2(N), channel index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable; low freezes the block and deasserts out_valid.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  SELW  channel index in manual mode.
- d  in  N*WIDTH  packed channel data; channel k is d[k*WIDTH +: WIDTH].
- out  out  WIDTH  registered selected data.
- out_ch  out  SELW  channel index that produced out.
- out_valid  out  1  out/out_ch are valid this cycle.
- wrap  out  1  one-cycle pulse when a scan passes from channel N-1 to channel 0.

Behaviour:
- Reset is asynchronous and active-high. While rst is high, and immediately on assertion:
  - out=0, out_ch=0, out_valid=0, wrap=0.
  - Internal scan channel ch=0, dwell counter dcnt=0, state=IDLE.
  - Reset mid-scan discards all progress; scanning restarts at channel 0 once rst is released.
- FSM states IDLE, MAN, SCAN. The next state is evaluated every clock:
  - en=0 -> IDLE.
  - en=1 and mode=0 -> MAN.
  - en=1 and mode=1 -> SCAN.
- IDLE:
  - out and out_ch hold their last values; out_valid=0; wrap=0.
  - ch and dcnt hold; en low pauses a scan without resetting it.
- MAN:
  - Latency 1 cycle: out<=d[sel], out_ch<=sel, out_valid<=1, wrap<=0.
  - If sel≥N (only possible when N is not a power of 2): out<=0, out_ch<=sel, out_valid<=0.
- SCAN:
  - Each enabled cycle: out<=d[ch], out_ch<=ch, out_valid<=1. d is sampled live every cycle, not latched at channel entry.
  - dcnt increments each cycle. When dcnt==DWELL-1: dcnt<=0 and ch advances.
  - ch advance: ch<=ch+1, or ch<=0 if ch==N-1.
  - wrap<=1 in the cycle that ch transitions N-1 -> 0; otherwise wrap<=0.
  - DWELL=1: ch advances every cycle and wrap pulses once every N cycles.
- Mode transitions while en=1:
  - MAN -> SCAN: ch<=0 and dcnt<=0 on the first SCAN cycle. The first scan output is channel 0, held for the full DWELL.
  - SCAN -> MAN: takes effect at the next edge. ch and dcnt are cleared.
- en dropping mid-dwell (SCAN -> IDLE -> SCAN with mode unchanged): the scan resumes at the same ch with the same remaining dwell.
- Simultaneous events:
  - rst dominates everything.
  - A change of mode and en in the same cycle resolves purely by the next-state rule above.
- Width rules:
  - dcnt is clog2(DWELL+1) bits wide.
  - ch comparisons use SELW-bit unsigned arithmetic; wrap to 0 is explicit and never relies on overflow.

Decomposition:
- Shared package (mux_pkg):
  - State encoding constants: ST_IDLE=2'd0, ST_MAN=2'd1, ST_SCAN=2'd2.
  - A clog2 helper function.
- One natural sub-module, scan_counter. It holds ch, dcnt and the wrap logic, with ports clk, rst, run, clear, ch, wrap_next.
- The top level holds the FSM, the data mux and the output registers.

Test Plan:
- Reset: assert rst=1 asynchronously mid-cycle during a scan at ch=5 -> all outputs go to 0 immediately. After release with en=1, mode=1, the first out_ch is 0.
- Manual select: N=8, WIDTH=1, d=8'b1010_0110, sel=3'd5, en=1, mode=0 -> one cycle later out=1, out_ch=5, out_valid=1. Then sel=3'd0 -> next cycle out=0, out_ch=0.
- Auto-scan: N=8, DWELL=4, d=8'hFF -> out_ch shows the sequence 0,0,0,0,1,1,1,1,…,7,7,7,7,0. wrap is high for exactly one cycle, coinciding with the first out_ch=0 after 7, i.e. 32 cycles after scan start.
- Pause: during a scan at ch=2 with dcnt=1, drop en for 3 cycles -> out_valid=0 and out/out_ch hold. Re-enable -> ch=2 is output for 2 more cycles, then ch=3.
- Mode switch: scanning at ch=6, set mode=0 with sel=1 -> next out_ch=1. Set mode=1 again -> scan restarts at ch=0 for the full DWELL.
- Non-power-of-2 edge: N=5, DWELL=1, mode=0, sel=3'd6 -> out=0, out_valid=0. Switch to mode=1 -> out_ch cycles 0..4 with wrap every 5 cycles.
